// File: rtl/inst_cache_refill.sv
// Direct-mapped instruction cache with word-serial line refill.
// Sits between the fetch stage and backing instruction memory.
module inst_cache_refill #(
    parameter int Inst_Width      = 32,
    parameter int Inst_Addr_Width = 17,
    parameter int LINE_WORDS      = 4,
    parameter int NUM_SETS        = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ce,
    input  logic [Inst_Addr_Width-1:0] addr,
    output logic                       ready,
    output logic [Inst_Width-1:0]      inst,
    output logic                       cache_enable,
    input  logic                       flush,
    output logic                       mem_req,
    output logic [Inst_Addr_Width-1:0] mem_addr,
    input  logic                       mem_valid,
    input  logic [Inst_Width-1:0]      mem_data,
    output logic [31:0]                hit_count,
    output logic [31:0]                miss_count
);

    localparam int OFF = $clog2(LINE_WORDS);
    localparam int IDX = $clog2(NUM_SETS);
    localparam int LO  = OFF + 2;
    localparam int TAG = Inst_Addr_Width - LO - IDX;
    localparam int WAW = Inst_Addr_Width - 2;

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        DRAIN,
        RESP
    } state_e;

    state_e                 state_q, state_d;
    logic [WAW-1:0]         waddr_q, waddr_d;
    logic [OFF-1:0]         beat_q, beat_d;
    logic                   mem_req_q, mem_req_d;
    logic [Inst_Addr_Width-1:0] mem_addr_q, mem_addr_d;
    logic                   cen_q, cen_d;
    logic [Inst_Width-1:0]  inst_q, inst_d;
    logic [31:0]            hit_q, hit_d;
    logic [31:0]            miss_q, miss_d;
    logic [NUM_SETS-1:0]    valid_q, valid_d;

    logic [TAG-1:0]         tag_q  [NUM_SETS];
    logic [Inst_Width-1:0]  data_q [NUM_SETS][LINE_WORDS];

    logic                   data_we;
    logic                   tag_we;

    logic [OFF-1:0]         in_off, q_off;
    logic [IDX-1:0]         in_idx, q_idx;
    logic [TAG-1:0]         in_tag, q_tag;
    logic                   lookup_hit;
    logic                   last_beat;
    logic                   unused_addr_bits;

    // Byte-offset bits never select anything; words are always aligned.
    assign unused_addr_bits = ^addr[1:0];

    assign in_off = addr[LO-1:2];
    assign in_idx = addr[LO+IDX-1:LO];
    assign in_tag = addr[Inst_Addr_Width-1:LO+IDX];

    assign q_off = waddr_q[OFF-1:0];
    assign q_idx = waddr_q[OFF+IDX-1:OFF];
    assign q_tag = waddr_q[WAW-1:OFF+IDX];

    assign lookup_hit = valid_q[in_idx] && (tag_q[in_idx] == in_tag);
    assign last_beat  = (beat_q == OFF'(LINE_WORDS - 1));

    assign ready        = (state_q == IDLE);
    assign inst         = inst_q;
    assign cache_enable = cen_q;
    assign mem_req      = mem_req_q;
    assign mem_addr     = mem_addr_q;
    assign hit_count    = hit_q;
    assign miss_count   = miss_q;

    // Next-state, lookup and refill sequencing.
    always_comb begin
        state_d    = state_q;
        waddr_d    = waddr_q;
        beat_d     = beat_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        cen_d      = 1'b0;
        inst_d     = inst_q;
        hit_d      = hit_q;
        miss_d     = miss_q;
        valid_d    = valid_q;
        data_we    = 1'b0;
        tag_we     = 1'b0;

        if (flush) begin
            valid_d = '0;
        end

        unique case (state_q)
            IDLE: begin
                if (ce) begin
                    waddr_d = addr[Inst_Addr_Width-1:2];
                    if (!flush && lookup_hit) begin
                        cen_d  = 1'b1;
                        inst_d = data_q[in_idx][in_off];
                        hit_d  = hit_q + 32'd1;
                    end else begin
                        miss_d     = miss_q + 32'd1;
                        state_d    = REFILL;
                        beat_d     = '0;
                        mem_req_d  = 1'b1;
                        mem_addr_d = {addr[Inst_Addr_Width-1:LO], {LO{1'b0}}};
                    end
                end
            end
            REFILL: begin
                if (mem_valid) begin
                    data_we   = 1'b1;
                    mem_req_d = 1'b0;
                    beat_d    = beat_q + 1'b1;
                    if (flush) begin
                        // A flush on the final beat leaves nothing to drain.
                        if (last_beat) begin
                            beat_d    = '0;
                            mem_req_d = 1'b1;
                        end else begin
                            state_d = DRAIN;
                        end
                    end else if (last_beat) begin
                        tag_we         = 1'b1;
                        valid_d[q_idx] = 1'b1;
                        state_d        = RESP;
                        cen_d          = 1'b1;
                        // The final word is still in flight to the array.
                        inst_d = (q_off == beat_q) ? mem_data
                                                   : data_q[q_idx][q_off];
                    end
                end else if (flush) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (mem_valid) begin
                    mem_req_d = 1'b0;
                    beat_d    = beat_q + 1'b1;
                    if (last_beat) begin
                        state_d   = REFILL;
                        beat_d    = '0;
                        mem_req_d = 1'b1;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state, outputs and counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            waddr_q    <= '0;
            beat_q     <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            cen_q      <= 1'b0;
            inst_q     <= '0;
            hit_q      <= '0;
            miss_q     <= '0;
            valid_q    <= '0;
        end else begin
            state_q    <= state_d;
            waddr_q    <= waddr_d;
            beat_q     <= beat_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            cen_q      <= cen_d;
            inst_q     <= inst_d;
            hit_q      <= hit_d;
            miss_q     <= miss_d;
            valid_q    <= valid_d;
        end
    end

    // Tag and data storage; contents are qualified by valid_q only.
    always_ff @(posedge clk) begin
        if (data_we) begin
            data_q[q_idx][beat_q] <= mem_data;
        end
        if (tag_we) begin
            tag_q[q_idx] <= q_tag;
        end
    end

endmodule

// File: doc/inst_cache_refill.md
Name: inst_cache_refill

Overview:
- Parametrised, clocked successor to the combinational instruction cache that feeds the CPU instruction queue.
- Direct-mapped instruction cache with tag/valid storage and a line-refill state machine against a word-serial instruction memory port.
- Supports a single-cycle flush (e.g. on self-modifying code or reset of the instruction stream).
- Sits between the CPU fetch stage (pc_icache_ce / icache_addr / icache_instq_inst / icache_instq_enable) and backing instruction memory.

Parameters:
- Inst_Width, 32, instruction word width in bits.
- Inst_Addr_Width, 17, byte address width; bits [1:0] ignored.
- LINE_WORDS, 4, words per line; power of 2, at least 2.
- NUM_SETS, 16, number of lines; power of 2, at least 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- ce  in  1  fetch request valid; sampled only when ready=1.
- addr  in  Inst_Addr_Width  fetch byte address, word-aligned.
- ready  out  1  controller in IDLE and able to accept ce.
- inst  out  Inst_Width  fetched instruction; valid only while cache_enable=1.
- cache_enable  out  1  one-cycle pulse: inst valid for the request last accepted.
- flush  in  1  invalidate all lines.
- mem_req  out  1  line-refill request; held high until the first mem_valid beat.
- mem_addr  out  Inst_Addr_Width  line-aligned byte address of refill (offset bits zero).
- mem_valid  in  1  one refill word present on mem_data.
- mem_data  in  Inst_Width  refill word; words arrive in ascending offset order.
- hit_count  out  32  accepted requests that hit; wraps modulo 2^32.
- miss_count  out  32  accepted requests that missed; wraps modulo 2^32.

Behaviour:
- Address split: word offset = addr[OFF+1:2] with OFF = log2(LINE_WORDS). Index = next log2(NUM_SETS) bits. Tag = remaining upper bits.
- Reset (rst=0, asynchronous):
  - All valid bits cleared; state IDLE.
  - ready=1, cache_enable=0, inst=0, mem_req=0, mem_addr=0, counters=0.
  - Data and tag arrays are not reset.
- IDLE:
  - If ce=1, capture addr and look up index.
  - Hit (valid and tag match): next cycle cache_enable=1, inst=data[index][offset], hit_count+1; stay in IDLE. Back-to-back hits therefore give one result per cycle, latency 1.
  - Miss: miss_count+1, go to REFILL, ready=0, mem_req=1, mem_addr=line base.
- REFILL:
  - Each mem_valid beat writes data[index][beat]; a beat counter runs 0 to LINE_WORDS-1.
  - mem_req drops after the first beat.
  - On the last beat: write tag, set valid, go to RESP.
- RESP:
  - One cycle: cache_enable=1, inst=word at the requested offset (read from the array or bypassed from the captured beat).
  - Return to IDLE; ready=1 in that next cycle.
  - Miss latency = cycles to first mem_valid + LINE_WORDS + 1.
- flush in IDLE: all valid bits cleared at that edge. If ce=1 in the same cycle, the lookup is treated as a miss; flush has priority.
- flush in REFILL: go to DRAIN.
  - DRAIN consumes the remaining beats without setting valid, then issues a fresh refill for the same captured address (REFILL again, miss_count not incremented again).
  - The pending request still completes with correct data.
- flush in RESP or DRAIN: clears valid bits, state flow unchanged.
- ce while ready=0 is ignored; the requester must hold ce/addr until ready=1.
- mem_valid outside REFILL/DRAIN is ignored.
- cache_enable is never high for two consecutive cycles for one request, and never high in REFILL or DRAIN.
- Reset mid-refill returns to IDLE immediately. In-flight memory beats are the memory side's responsibility; they are ignored after reset.

Test Plan:
- Reset, then ce=1, addr=0x00040. Memory returns 4 beats 0xA0,0xA1,0xA2,0xA3 one per cycle after mem_req. Required:
  - mem_addr=0x00040.
  - cache_enable one cycle after the last beat with inst=0xA0.
  - miss_count=1.
- Same line again, then addr=0x0004C the next cycle. Required:
  - cache_enable on consecutive cycles with inst=0xA0 then 0xA3.
  - hit_count=2, mem_req never asserted.
- Conflict: fill 0x00040, then request 0x00140 (same index 4, different tag). Required:
  - miss and refill; then 0x00040 misses again.
  - miss_count=3.
- flush in IDLE after the line is filled, then request 0x00040. Required: miss, mem_req=1.
- flush asserted during beat 2 of a refill for 0x00044. Required:
  - Remaining beats drained.
  - A second mem_req to 0x00040.
  - Final inst = 2nd word of the second transfer.
  - miss_count incremented only once.
- rst pulled low mid-REFILL. Required:
  - Immediately ready=1, cache_enable=0, mem_req=0, counters=0.
  - A subsequent request to the same address misses.
